sync_fifo_prog: RTL and testbench

//  Single-clock FIFO, parametrised in width and any depth >= 2 (not only powers of two).

---
 rtl/sync_fifo_prog.sv | 150 +++++++++++++++
 tb/tb_sync_fifo_prog.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO for any DEPTH >= 2 (power of two not required), with an
//   occupancy count, almost-full/almost-empty thresholds, sticky overflow and
//   underflow flags, and a synchronous flush.
//
//   Configuration macro: SYNC_FIFO_FWFT_EN
//     defined   -> first-word-fall-through: o_rdata shows the head word
//                  combinationally and o_rvalid = !o_empty (latency 0).
//     undefined -> standard mode: an accepted pop registers mem[rptr] into
//                  o_rdata and pulses o_rvalid the next cycle (latency 1).
//
//   Ports
//     i_clk, i_rst           clock (rising edge), async active-high reset
//     i_push, i_wdata        write request and data
//     i_pop                  read request
//     o_rdata, o_rvalid      read data and its valid
//     i_flush                synchronous clear of contents
//     i_clr_err              clears the sticky error flags
//     o_full, o_empty        count == DEPTH / count == 0
//     o_afull, o_aempty      count >= AFULL_TH / count <= AEMPTY_TH
//     o_count                occupancy 0..DEPTH
//     o_overflow             sticky: push attempted while full
//     o_underflow            sticky: pop attempted while empty
module sync_fifo_prog #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  input  logic             i_flush,
  input  logic             i_clr_err,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_afull,
  output logic             o_aempty,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty;
  logic             push_ok, pop_ok;
  logic             ovf_evt, udf_evt;

  // Explicit wrap compare so non-power-of-two depths cycle correctly.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Flush masks both requests, so it neither moves data nor raises errors.
  assign push_ok = i_push && !full  && !i_flush;
  assign pop_ok  = i_pop  && !empty && !i_flush;
  assign ovf_evt = i_push && full   && !i_flush;
  assign udf_evt = i_pop  && empty  && !i_flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = next_ptr(wptr_q);
      if (pop_ok)  rptr_d = next_ptr(rptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    // A new error in the same cycle as a clear keeps the flag set.
    if (ovf_evt)        ovf_d = 1'b1;
    else if (i_clr_err) ovf_d = 1'b0;
    if (udf_evt)        udf_d = 1'b1;
    else if (i_clr_err) udf_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q] <= i_wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Drive zero while empty so the output is defined after reset.
  assign o_rdata  = empty ? '0 : mem_q[rptr_q];
  assign o_rvalid = !empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= pop_ok;
      if (pop_ok) rdata_q <= mem_q[rptr_q];
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
`endif

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_afull     = (count_q >= CW'(AFULL_TH));
  assign o_aempty    = (count_q <= CW'(AEMPTY_TH));
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
//   Scoreboard bench for sync_fifo_prog (WIDTH=8, DEPTH=5, AFULL_TH=4,
//   AEMPTY_TH=1). A queue-based reference model tracks contents and sticky
//   flags; accepted pops push expected read data to a scoreboard queue that a
//   separate monitor drains whenever the DUT presents o_rvalid.
module tb_sync_fifo_prog;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AFTH  = 4;
  localparam int AETH  = 1;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_push = 1'b0;
  logic [WIDTH-1:0] i_wdata = '0;
  logic             i_pop = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_clr_err = 1'b0;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             o_full, o_empty, o_afull, o_aempty;
  logic [3:0]       o_count;
  logic             o_overflow, o_underflow;

  sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFTH), .AEMPTY_TH(AETH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_push(i_push), .i_wdata(i_wdata), .i_pop(i_pop),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_flush(i_flush), .i_clr_err(i_clr_err),
    .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull), .o_aempty(o_aempty),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_q[$];
  int expq[$];
  bit m_ovf = 0;
  bit m_udf = 0;
  bit done  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void check_status();
    int n;
    n = model_q.size();
    chk("count", int'(o_count), n);
    chk("full", int'(o_full), int'(n == DEPTH));
    chk("empty", int'(o_empty), int'(n == 0));
    chk("afull", int'(o_afull), int'(n >= AFTH));
    chk("aempty", int'(o_aempty), int'(n <= AETH));
    chk("overflow", int'(o_overflow), int'(m_ovf));
    chk("underflow", int'(o_underflow), int'(m_udf));
  endfunction

  // One clock of stimulus; the model is advanced from its pre-edge state.
  task automatic step(input bit push, input int d, input bit pop, input bit flush, input bit clr);
    bit full, empty;
    int v;
    i_push = push; i_wdata = d[WIDTH-1:0]; i_pop = pop; i_flush = flush; i_clr_err = clr;
    @(posedge clk);
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (flush) begin
      model_q.delete();
      if (clr) begin m_ovf = 0; m_udf = 0; end
    end else begin
      if (push && full) m_ovf = 1;
      else if (clr)     m_ovf = 0;
      if (pop && empty) m_udf = 1;
      else if (clr)     m_udf = 0;
      if (pop && !empty) begin
        v = model_q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        expq.push_back(v);
`endif
      end
      if (push && !full) model_q.push_back(d & 8'hFF);
    end
    #1;
    check_status();
  endtask

  task automatic idle();
    i_push = 0; i_pop = 0; i_flush = 0; i_clr_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    idle();
    i_rst = 1'b1;
    expq.delete();
    model_q.delete();
    m_ovf = 0; m_udf = 0;
    #1;
    check_status();
    chk("rst_rdata", int'(o_rdata), 0);
    chk("rst_rvalid", int'(o_rvalid), 0);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // Monitor: compares every presented read against the scoreboard/model.
  initial begin
    forever begin
      @(negedge clk);
      if (!i_rst && !done) begin
`ifdef SYNC_FIFO_FWFT_EN
        chk("rvalid", int'(o_rvalid), int'(model_q.size() != 0));
        if (model_q.size() != 0) chk("rdata", int'(o_rdata), model_q[0]);
`else
        chk("rvalid", int'(o_rvalid), int'(expq.size() != 0));
        if (o_rvalid && expq.size() != 0) chk("rdata", int'(o_rdata), expq.pop_front());
`endif
      end
    end
  end

  initial begin
    do_reset();

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, 8'h11 + i, 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Three fill/drain rounds to exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) step(1, $urandom_range(0, 255), 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
    end

    // Simultaneous push/pop at count 2, then at count 0.
    step(1, 8'h21, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h30 + i, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 8'h44, 1, 0, 0);

    // Underflow and error clear.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Flush beats a push.
    for (int i = 0; i < 3; i++) step(1, 8'h50 + i, 0, 0, 0);
    step(1, 8'h5F, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Reset mid-operation, then a single push.
    for (int i = 0; i < 3; i++) step(1, 8'h60 + i, 0, 0, 0);
    do_reset();
    step(1, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Randomised traffic including occasional flush and clear.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
    idle();
    @(negedge clk);
    @(negedge clk);
    done = 1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
